carry_save_column_resolver: RTL and testbench

Converts the carry-save column output of the polynomial multiplier into canonical binary. It takes `NUM_COLS` column pairs (S, Cout), each `OUT_BIT_LEN` bits wide and weighted 2^(WORD_LEN·i). It streams out `NUM_COLS` fully-propagated `WORD_LEN`-bit words, least significant first, followed by the residual carry. It sits directly after the multiplier's column registers, closing the carry-save loop toward reduction/output logic.

---
 rtl/carry_save_column_resolver.sv | 227 ++++++++++++++++++++++
 tb/tb_carry_save_column_resolver.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_save_column_resolver.sv
// -----------------------------------------------------------------------------
// carry_save_column_resolver
//
// Turns the carry-save column output of the polynomial multiplier (one S and one
// Cout column per output word position, each OUT_BIT_LEN bits wide and weighted
// 2^(WORD_LEN*i)) into canonical binary. The column arrays are snapshotted on
// an accepted start. The block then streams NUM_COLS fully propagated WORD_LEN-bit
// words, least significant first, with a ready/valid handshake. Finally it reports
// the residual carry out of the top column.
//
// Optional feature macro: CARRY_SAVE_RESOLVER_OVERFLOW_EN
//   defined   : overflow is a sticky flag raised with done when final_carry != 0
//   undefined : overflow is tied low and no comparison logic is built
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous active-high reset
//   start        in   request to capture S/Cout (accepted only while in_ready)
//   in_ready     out  block idle, start will be accepted
//   S            in   NUM_COLS sum columns, column i at [i*OUT_BIT_LEN +: OUT_BIT_LEN]
//   Cout         in   NUM_COLS carry columns, same packing, already weight-aligned
//   out_valid    out  out_word is valid
//   out_ready    in   downstream accepts out_word this cycle
//   out_word     out  resolved word for column out_index
//   out_index    out  column index of out_word
//   out_last     out  out_index is the top column
//   done         out  one-cycle pulse, final_carry valid
//   final_carry  out  carry out of the top column
//   overflow     out  final_carry non-zero (feature macro only)
// -----------------------------------------------------------------------------
module carry_save_column_resolver #(
    parameter int NUM_ELEMENTS = 34,
    parameter int WORD_LEN     = 16,
    parameter int OUT_BIT_LEN  = WORD_LEN + $clog2(NUM_ELEMENTS * 2),
    parameter int NUM_COLS     = NUM_ELEMENTS * 2 + 1,
    parameter int CARRY_LEN    = OUT_BIT_LEN - WORD_LEN + 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    output logic                            in_ready,
    input  logic [NUM_COLS*OUT_BIT_LEN-1:0] S,
    input  logic [NUM_COLS*OUT_BIT_LEN-1:0] Cout,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WORD_LEN-1:0]             out_word,
    output logic [$clog2(NUM_COLS)-1:0]     out_index,
    output logic                            out_last,
    output logic                            done,
    output logic [CARRY_LEN-1:0]            final_carry,
    output logic                            overflow
);

    localparam int IDX_W = $clog2(NUM_COLS);
    // Two extra bits hold S + Cout + carry without loss; the upper
    // CARRY_LEN bits of this width are exactly the next inter-column carry.
    localparam int SUM_W = OUT_BIT_LEN + 2;
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       col_q, col_d;
    logic [CARRY_LEN-1:0]   carry_q, carry_d;
    logic [CARRY_LEN-1:0]   final_carry_q, final_carry_d;
    logic [OUT_BIT_LEN-1:0] s_q    [NUM_COLS];
    logic [OUT_BIT_LEN-1:0] s_d    [NUM_COLS];
    logic [OUT_BIT_LEN-1:0] cout_q [NUM_COLS];
    logic [OUT_BIT_LEN-1:0] cout_d [NUM_COLS];
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   done_q, done_d;

    logic [SUM_W-1:0]       sum_s;
    logic [CARRY_LEN-1:0]   carry_next_s;
    logic                   accept_s;
    logic                   transfer_s;
    logic                   finish_s;

    // Column adder: the single combinational path feeding out_word.
    always_comb begin
        sum_s = SUM_W'(s_q[col_q]) + SUM_W'(cout_q[col_q]) + SUM_W'(carry_q);
    end

    assign carry_next_s = sum_s[WORD_LEN +: CARRY_LEN];
    assign accept_s     = (state_q == ST_IDLE) && start;
    assign transfer_s   = (state_q == ST_RUN) && out_valid_q && out_ready;
    assign finish_s     = transfer_s && (col_q == LAST_COL);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        carry_d       = carry_q;
        final_carry_d = final_carry_q;
        s_d           = s_q;
        cout_d        = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_RUN;
                    col_d         = {IDX_W{1'b0}};
                    carry_d       = {CARRY_LEN{1'b0}};
                    final_carry_d = {CARRY_LEN{1'b0}};
                    for (int i = 0; i < NUM_COLS; i++) begin
                        s_d[i]    = S[i*OUT_BIT_LEN +: OUT_BIT_LEN];
                        cout_d[i] = Cout[i*OUT_BIT_LEN +: OUT_BIT_LEN];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (finish_s) begin
                    // Column pointer and carry are parked at 0 so the idle
                    // state presents out_index = 0.
                    final_carry_d = carry_next_s;
                    col_d         = {IDX_W{1'b0}};
                    carry_d       = {CARRY_LEN{1'b0}};
                    state_d       = ST_DONE;
                end else if (transfer_s) begin
                    carry_d = carry_next_s;
                    col_d   = col_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                col_d   = {IDX_W{1'b0}};
                carry_d = {CARRY_LEN{1'b0}};
            end
        endcase

        // Handshake/status outputs are decoded from the next state so they
        // come straight out of flops.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_RUN);
        done_d      = (state_d == ST_DONE);
        out_last_d  = (state_d == ST_RUN) && (col_d == LAST_COL);
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            col_q         <= {IDX_W{1'b0}};
            carry_q       <= {CARRY_LEN{1'b0}};
            final_carry_q <= {CARRY_LEN{1'b0}};
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            carry_q       <= carry_d;
            final_carry_q <= final_carry_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            done_q        <= done_d;
        end
    end

    // Column snapshot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                s_q[i]    <= {OUT_BIT_LEN{1'b0}};
                cout_q[i] <= {OUT_BIT_LEN{1'b0}};
            end
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

`ifdef CARRY_SAVE_RESOLVER_OVERFLOW_EN
    logic overflow_q, overflow_d;

    // Sticky overflow: raised together with done, cleared by the next start.
    always_comb begin
        overflow_d = overflow_q;
        if (accept_s) begin
            overflow_d = 1'b0;
        end else if (finish_s) begin
            overflow_d = (carry_next_s != {CARRY_LEN{1'b0}});
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    // Outside a stream the snapshot may still hold data, so the word is
    // forced to zero whenever it is not valid.
    assign out_word    = out_valid_q ? sum_s[WORD_LEN-1:0] : {WORD_LEN{1'b0}};
    assign out_index   = col_q;
    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign done        = done_q;
    assign final_carry = final_carry_q;

endmodule

// File: tb/tb_carry_save_column_resolver.sv
// -----------------------------------------------------------------------------
// Self-checking bench for carry_save_column_resolver (default parameters).
// The reference model adds every column pair at its weight into one wide
// integer. It then slices that integer into words; the residual carry is
// whatever lies above the top word.
// -----------------------------------------------------------------------------
module tb_carry_save_column_resolver;

    localparam int NC  = 69;
    localparam int OBL = 23;
    localparam int WL  = 16;
    localparam int CL  = 9;
    localparam int IW  = 7;
    localparam int TW  = 1120;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               in_ready;
    logic [NC*OBL-1:0]  s_bus;
    logic [NC*OBL-1:0]  c_bus;
    logic               out_valid;
    logic               out_ready;
    logic [WL-1:0]      out_word;
    logic [IW-1:0]      out_index;
    logic               out_last;
    logic               done;
    logic [CL-1:0]      final_carry;
    logic               overflow;

    carry_save_column_resolver dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_ready    (in_ready),
        .S           (s_bus),
        .Cout        (c_bus),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_index   (out_index),
        .out_last    (out_last),
        .done        (done),
        .final_carry (final_carry),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [OBL-1:0] s_arr [NC];
    logic [OBL-1:0] c_arr [NC];
    logic [WL-1:0]  exp_words [NC];
    logic [CL-1:0]  exp_fc;
    logic           exp_ovf;

    bit             mon_en = 1'b0;
    int             exp_idx;
    int             stalls;
    bit             stalled_prev;
    logic [WL-1:0]  stalled_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Model: total = sum_i (S[i] + Cout[i]) * 2^(16*i); words are its slices.
    task automatic build_model();
        logic [TW-1:0] total;
        logic [TW-1:0] term;
        total = '0;
        for (int i = 0; i < NC; i++) begin
            term  = TW'(s_arr[i]) + TW'(c_arr[i]);
            total = total + (term << (WL * i));
            s_bus[i*OBL +: OBL] = s_arr[i];
            c_bus[i*OBL +: OBL] = c_arr[i];
        end
        for (int i = 0; i < NC; i++) exp_words[i] = total[WL*i +: WL];
        exp_fc = total[NC*WL +: CL];
`ifdef CARRY_SAVE_RESOLVER_OVERFLOW_EN
        exp_ovf = (exp_fc != '0);
`else
        exp_ovf = 1'b0;
`endif
    endtask

    task automatic fill(input logic [OBL-1:0] sv, input logic [OBL-1:0] cv);
        for (int i = 0; i < NC; i++) begin
            s_arr[i] = sv;
            c_arr[i] = cv;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NC; i++) begin
            s_arr[i] = OBL'($urandom);
            c_arr[i] = OBL'($urandom);
        end
    endtask

    // Compare process: every valid word against the model, plus end-of-stream status.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (out_valid) begin
                if (exp_idx < NC) begin
                    chk("out_index", 32'(out_index), 32'(exp_idx));
                    chk("out_word", 32'(out_word), 32'(exp_words[exp_idx]));
                    chk("out_last", 32'(out_last), 32'(exp_idx == NC - 1));
                end else begin
                    chk("extra_word", 32'(out_valid), 32'd0);
                end
                if (stalled_prev) chk("stall_hold", 32'(out_word), 32'(stalled_word));
                if (out_ready) begin
                    exp_idx++;
                    stalled_prev = 1'b0;
                end else begin
                    stalls++;
                    stalled_prev = 1'b1;
                    stalled_word = out_word;
                end
            end
            if (done) begin
                chk("final_carry", 32'(final_carry), 32'(exp_fc));
                chk("overflow", 32'(overflow), 32'(exp_ovf));
                chk("words_seen", 32'(exp_idx), 32'(NC));
            end
        end
    end

    // One stream. stall: random out_ready; busy_at: cycle to pulse start with
    // scrambled inputs (-1 none); abort_idx: out_index at which to reset (-1 none).
    task automatic run_stream(input bit stall, input int busy_at, input int abort_idx);
        int n;
        bit seen;
        exp_idx      = 0;
        stalls       = 0;
        stalled_prev = 1'b0;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_before_start", 32'(in_ready), 32'd1);
        mon_en    = 1'b1;
        start     = 1'b1;
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n     = 1;
        seen  = 1'b0;
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        while (n < 3000) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            chk("valid_mid_stream", 32'(out_valid), 32'd1);
            if (abort_idx >= 0 && out_index == IW'(abort_idx)) begin
                mon_en = 1'b0;
                reset  = 1'b1;
                #1;
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_in_ready", 32'(in_ready), 32'd1);
                chk("rst_out_index", 32'(out_index), 32'd0);
                chk("rst_out_word", 32'(out_word), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_final_carry", 32'(final_carry), 32'd0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (n == busy_at) begin
                start = 1'b1;
                s_bus = ~s_bus;
                c_bus = ~c_bus;
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("done_latency", 32'(n), 32'(NC + 1 + stalls));
        chk("done_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("post_done", 32'(done), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("held_final_carry", 32'(final_carry), 32'(exp_fc));
        chk("held_overflow", 32'(overflow), 32'(exp_ovf));
        mon_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        s_bus     = '0;
        c_bus     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_word", 32'(out_word), 32'd0);
        chk("reset_out_index", 32'(out_index), 32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_final_carry", 32'(final_carry), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // All-zero columns.
        fill(23'h0, 23'h0);
        build_model();
        chk("model_zero_w68", 32'(exp_words[68]), 32'h0);
        run_stream(1'b0, -1, -1);

        // Single carry ripple.
        fill(23'h0, 23'h0);
        s_arr[0] = 23'h00FFFF;
        c_arr[0] = 23'h000001;
        build_model();
        chk("model_ripple_w0", 32'(exp_words[0]), 32'h0000);
        chk("model_ripple_w1", 32'(exp_words[1]), 32'h0001);
        chk("model_ripple_w2", 32'(exp_words[2]), 32'h0000);
        chk("model_ripple_fc", 32'(exp_fc), 32'h0);
        run_stream(1'b0, -1, -1);

        // Maximum columns.
        fill(23'h7FFFFF, 23'h7FFFFF);
        build_model();
        chk("model_max_w0", 32'(exp_words[0]), 32'hFFFE);
        chk("model_max_w1", 32'(exp_words[1]), 32'h00FD);
        chk("model_max_w2", 32'(exp_words[2]), 32'h00FE);
        chk("model_max_w68", 32'(exp_words[68]), 32'h00FE);
        chk("model_max_fc", 32'(exp_fc), 32'h100);
        run_stream(1'b0, -1, -1);
        // Same data under backpressure.
        run_stream(1'b1, -1, -1);

        // Random data, no stall then 50% backpressure.
        fill_random();
        build_model();
        run_stream(1'b0, -1, -1);
        run_stream(1'b1, -1, -1);

        // Reset mid-stream at index 30, then a full fresh stream.
        fill(23'h7FFFFF, 23'h7FFFFF);
        build_model();
        run_stream(1'b0, -1, 30);
        fill_random();
        build_model();
        run_stream(1'b0, -1, -1);

        // Start while busy: scrambled inputs and a start pulse are ignored.
        fill_random();
        build_model();
        run_stream(1'b0, 10, -1);
        fill_random();
        build_model();
        run_stream(1'b1, 40, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
